coreaxitoahbl_rd_xfer_sched: RTL and testbench

//  Read-transfer scheduler for the AXI-to-AHB-Lite bridge read path. Accepts one AXI read command.

---
 rtl/coreaxitoahbl_rd_xfer_sched_if.sv | 30 +++
 rtl/coreaxitoahbl_rd_xfer_sched.sv | 120 ++++++++++++
 tb/tb_coreaxitoahbl_rd_xfer_sched.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coreaxitoahbl_rd_xfer_sched_if.sv
// Handshake bundle between the AXI read-address decode, the read-transfer scheduler
// and the AHB master control FSM. The scheduler connects through the slave modport.
interface coreaxitoahbl_rd_xfer_sched_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_offset;
    logic [3:0] cmd_len;
    logic [7:0] total_bytes;
    logic       xfer_valid;
    logic       xfer_ready;
    logic [2:0] xfer_bytes;
    logic       xfer_first;
    logic       xfer_last;
    logic       rsp_valid;
    logic       busy;
    logic       done;
    logic       proto_err;

    modport slave (
        input  cmd_valid, cmd_offset, cmd_len, xfer_ready, rsp_valid,
        output cmd_ready, total_bytes, xfer_valid, xfer_bytes, xfer_first, xfer_last,
        output busy, done, proto_err
    );

    modport master (
        output cmd_valid, cmd_offset, cmd_len, xfer_ready, rsp_valid,
        input  cmd_ready, total_bytes, xfer_valid, xfer_bytes, xfer_first, xfer_last,
        input  busy, done, proto_err
    );
endinterface

// File: rtl/coreaxitoahbl_rd_xfer_sched.sv
// Read-transfer scheduler: sizes one AXI read command and splits it into AHB
// word-or-smaller transfer requests, throttled by an outstanding-response limit.
module coreaxitoahbl_rd_xfer_sched #(
    parameter int AXI_DWIDTH      = 64,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                               ACLK,
    input  logic                               ARESETN,
    coreaxitoahbl_rd_xfer_sched_if.slave       bus
);

    localparam int         BYTES    = AXI_DWIDTH / 8;
    localparam logic [2:0] OFF_MASK = 3'(BYTES - 1);
    localparam logic [2:0] MAX_OUT  = 3'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CALC  = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } stateT;

    stateT      stateQ;
    stateT      stateD;
    logic [2:0] offQ;
    logic [3:0] lenQ;
    logic [7:0] totalBytesQ;
    logic [7:0] remainingQ;
    logic [2:0] outstandingQ;
    logic       firstPendQ;
    logic       protoErrQ;

    logic [7:0] lenPlusOne;
    logic [7:0] beatBytes;
    logic [7:0] calcTotal;
    logic [2:0] headBytes;
    logic [2:0] chunkBytes;
    logic       xferValid;
    logic       issue;
    logic       rspOk;
    logic       rspErr;

    // Valid bytes per beat shrink by the start offset on every beat of the burst.
    assign lenPlusOne = 8'(lenQ) + 8'd1;
    assign beatBytes  = 8'(BYTES) - 8'(offQ);
    assign calcTotal  = lenPlusOne * beatBytes;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        stateD     = stateQ;
        headBytes  = 3'd4;
        if (firstPendQ && (offQ[1:0] != 2'd0)) begin
            headBytes = 3'd4 - {1'b0, offQ[1:0]};
        end
        chunkBytes = (remainingQ < {5'd0, headBytes}) ? remainingQ[2:0] : headBytes;
        xferValid  = (stateQ == ISSUE) && (remainingQ != 8'd0) && (outstandingQ < MAX_OUT);
        issue      = xferValid && bus.xfer_ready;
        rspOk      = bus.rsp_valid && (outstandingQ != 3'd0);
        rspErr     = bus.rsp_valid && (outstandingQ == 3'd0);

        unique case (stateQ)
            IDLE:  if (bus.cmd_valid) stateD = CALC;
            CALC:  stateD = ISSUE;
            ISSUE: if (issue && ({5'd0, chunkBytes} == remainingQ)) stateD = DRAIN;
            DRAIN: if (outstandingQ == 3'd0) stateD = DONE;
            DONE:  stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            stateQ       <= IDLE;
            offQ         <= 3'd0;
            lenQ         <= 4'd0;
            totalBytesQ  <= 8'd0;
            remainingQ   <= 8'd0;
            outstandingQ <= 3'd0;
            firstPendQ   <= 1'b0;
            protoErrQ    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            stateQ    <= stateD;
            protoErrQ <= rspErr;

            if ((stateQ == IDLE) && bus.cmd_valid) begin
                offQ <= bus.cmd_offset & OFF_MASK;
                lenQ <= bus.cmd_len;
            end

            if (stateQ == CALC) begin
                totalBytesQ <= calcTotal;
                remainingQ  <= calcTotal;
                firstPendQ  <= 1'b1;
            end else if (issue) begin
                remainingQ <= remainingQ - {5'd0, chunkBytes};
                firstPendQ <= 1'b0;
            end

            // A stray response with nothing outstanding is flagged and otherwise dropped.
            unique case ({issue, rspOk})
                2'b10:   outstandingQ <= outstandingQ + 3'd1;
                2'b01:   outstandingQ <= outstandingQ - 3'd1;
                default: outstandingQ <= outstandingQ;
            endcase
        end
    end

    assign bus.cmd_ready   = (stateQ == IDLE);
    assign bus.busy        = (stateQ != IDLE);
    assign bus.done        = (stateQ == DONE);
    assign bus.proto_err   = protoErrQ;
    assign bus.total_bytes = totalBytesQ;
    assign bus.xfer_valid  = xferValid;
    assign bus.xfer_bytes  = chunkBytes;
    assign bus.xfer_first  = (stateQ == ISSUE) && firstPendQ;
    assign bus.xfer_last   = (stateQ == ISSUE) && ({5'd0, chunkBytes} == remainingQ);

endmodule

// File: tb/tb_coreaxitoahbl_rd_xfer_sched.sv
// Bench for the read-transfer scheduler: a 64-bit and a 32-bit instance share one
// stimulus; a select picks which one is observed and scored.
module tb_coreaxitoahbl_rd_xfer_sched;

    logic       ACLK      = 1'b0;
    logic       ARESETN   = 1'b0;
    logic       cmdValid  = 1'b0;
    logic [2:0] cmdOffset = 3'd0;
    logic [3:0] cmdLen    = 4'd0;
    logic       xferReady = 1'b1;
    logic       manualRsp = 1'b0;
    logic       autoRsp   = 1'b1;
    logic       sel32     = 1'b0;
    logic       rspPulse;
    logic       rspValid;

    always #5 ACLK = ~ACLK;

    coreaxitoahbl_rd_xfer_sched_if i64 ();
    coreaxitoahbl_rd_xfer_sched_if i32 ();

    assign rspValid = manualRsp | rspPulse;
    assign i64.cmd_valid  = cmdValid;
    assign i64.cmd_offset = cmdOffset;
    assign i64.cmd_len    = cmdLen;
    assign i64.xfer_ready = xferReady;
    assign i64.rsp_valid  = rspValid;
    assign i32.cmd_valid  = cmdValid;
    assign i32.cmd_offset = cmdOffset;
    assign i32.cmd_len    = cmdLen;
    assign i32.xfer_ready = xferReady;
    assign i32.rsp_valid  = rspValid;

    coreaxitoahbl_rd_xfer_sched #(.AXI_DWIDTH(64), .MAX_OUTSTANDING(2)) u64 (
        .ACLK(ACLK), .ARESETN(ARESETN), .bus(i64)
    );
    coreaxitoahbl_rd_xfer_sched #(.AXI_DWIDTH(32), .MAX_OUTSTANDING(2)) u32 (
        .ACLK(ACLK), .ARESETN(ARESETN), .bus(i32)
    );

    logic       sCmdReady, sXferValid, sXferFirst, sXferLast, sBusy, sDone, sProtoErr;
    logic [2:0] sXferBytes;
    logic [7:0] sTotalBytes;

    always_comb begin
        if (sel32) begin
            sCmdReady = i32.cmd_ready;  sXferValid = i32.xfer_valid; sXferFirst = i32.xfer_first;
            sXferLast = i32.xfer_last;  sBusy = i32.busy;            sDone = i32.done;
            sProtoErr = i32.proto_err;  sXferBytes = i32.xfer_bytes; sTotalBytes = i32.total_bytes;
        end else begin
            sCmdReady = i64.cmd_ready;  sXferValid = i64.xfer_valid; sXferFirst = i64.xfer_first;
            sXferLast = i64.xfer_last;  sBusy = i64.busy;            sDone = i64.done;
            sProtoErr = i64.proto_err;  sXferBytes = i64.xfer_bytes; sTotalBytes = i64.total_bytes;
        end
    end

    typedef struct {
        logic [2:0] bytes;
        logic       first;
        logic       last;
    } xfer_t;

    typedef struct {
        bit         is32;
        logic [2:0] off;
        logic [3:0] len;
        int         expTotal;
        int         expXfers;
    } vec_t;

    xfer_t expQ[$];
    xfer_t monExp;
    vec_t  tab[9];
    int    passCount  = 0;
    int    checkCount = 0;
    int    hsCount    = 0;
    int    doneCount  = 0;
    int    errCount   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        else passCount++;
    endtask

    // Responder: answers each accepted request one cycle later when enabled.
    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) rspPulse <= 1'b0;
        else          rspPulse <= autoRsp && sXferValid && xferReady;
    end

    // Scoreboard consumer: every request that will be accepted at the next edge is scored.
    always @(negedge ACLK) begin
        if (ARESETN) begin
            if (sDone)     doneCount++;
            if (sProtoErr) errCount++;
            if (sXferValid && xferReady) begin
                hsCount++;
                if (expQ.size() == 0) begin
                    check("xfer_unexpected", expQ.size(), 1);
                end else begin
                    monExp = expQ.pop_front();
                    check("xfer_req", {sXferBytes, sXferFirst, sXferLast},
                          {monExp.bytes, monExp.first, monExp.last});
                end
            end
        end
    end

    // Reference chunking of one command into expected requests.
    task automatic push_expected(input bit is32, input logic [2:0] off, input logic [3:0] len);
        int    nb;
        int    o;
        int    rem;
        int    c;
        bit    first;
        xfer_t x;
        nb    = is32 ? 4 : 8;
        o     = int'(off) & (nb - 1);
        rem   = (int'(len) + 1) * (nb - o);
        first = 1'b1;
        while (rem > 0) begin
            c = (first && (o % 4) != 0) ? 4 - (o % 4) : 4;
            if (c > rem) c = rem;
            x.bytes = 3'(c);
            x.first = first;
            x.last  = (c == rem);
            expQ.push_back(x);
            rem   -= c;
            first  = 1'b0;
        end
    endtask

    task automatic do_reset(input bit s);
        cmdValid  = 1'b0;
        manualRsp = 1'b0;
        ARESETN   = 1'b0;
        sel32     = s;
        repeat (2) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        expQ.delete();
        hsCount = 0;
    endtask

    task automatic start_cmd(input bit is32, input logic [2:0] off, input logic [3:0] len,
                             input int expTotal);
        if (sel32 != is32) do_reset(is32);
        push_expected(is32, off, len);
        hsCount = 0;
        @(posedge ACLK); #1;
        cmdValid  = 1'b1;
        cmdOffset = off;
        cmdLen    = len;
        @(negedge ACLK);
        check("cmd_ready_idle", sCmdReady, 1);
        @(posedge ACLK); #1;
        cmdValid = 1'b0;
        @(negedge ACLK);
        check("calc_no_xfer", {sXferValid, sBusy, sCmdReady}, 3'b010);
        @(negedge ACLK);
        check("first_xfer_valid", sXferValid, 1);
        check("total_bytes", sTotalBytes, 32'(expTotal));
    endtask

    task automatic finish_cmd(input int expXfers, input int doneBefore, input int errBefore);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge ACLK);
            if (sDone) got = 1'b1;
        end
        check("done_seen", got, 1);
        @(negedge ACLK);
        check("done_one_cycle", {sDone, sBusy, sCmdReady}, 3'b001);
        check("xfer_count", hsCount, expXfers);
        check("queue_drained", expQ.size(), 0);
        check("done_count", doneCount - doneBefore, 1);
        check("no_proto_err", errCount - errBefore, 0);
    endtask

    task automatic run_row(input vec_t v);
        int d0;
        int e0;
        d0 = doneCount;
        e0 = errCount;
        start_cmd(v.is32, v.off, v.len, v.expTotal);
        finish_cmd(v.expXfers, d0, e0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0;
        int e0;
        tab[0] = '{1'b0, 3'd0, 4'd0,   8,  2};
        tab[1] = '{1'b0, 3'd1, 4'd1,  14,  4};
        tab[2] = '{1'b0, 3'd7, 4'd15, 16,  5};
        tab[3] = '{1'b0, 3'd0, 4'd15, 128, 32};
        tab[4] = '{1'b0, 3'd5, 4'd0,   3,  1};
        tab[5] = '{1'b1, 3'd3, 4'd15, 16,  5};
        tab[6] = '{1'b1, 3'd7, 4'd15, 16,  5};
        tab[7] = '{1'b1, 3'd0, 4'd0,   4,  1};
        tab[8] = '{1'b1, 3'd2, 4'd2,   6,  2};

        do_reset(1'b0);
        @(negedge ACLK);
        check("reset_state", {sCmdReady, sBusy, sXferValid, sDone, sProtoErr, sXferFirst, sXferLast},
              7'b1000000);
        check("reset_total", sTotalBytes, 0);

        for (int i = 0; i < 5; i++) run_row(tab[i]);

        // Outstanding limit: no responses, then single and back-to-back responses.
        autoRsp = 1'b0;
        e0 = errCount;
        start_cmd(1'b0, 3'd0, 4'd3, 32);
        repeat (3) @(negedge ACLK);
        check("limit_two_issued", hsCount, 2);
        check("limit_stall", {sXferValid, sXferBytes, sXferFirst, sXferLast}, {1'b0, 3'd4, 1'b0, 1'b0});
        @(posedge ACLK); #1 manualRsp = 1'b1;
        @(posedge ACLK); #1 manualRsp = 1'b0;
        repeat (3) @(negedge ACLK);
        check("single_rsp_release", hsCount, 3);
        check("limit_again", sXferValid, 0);
        @(posedge ACLK); #1 manualRsp = 1'b1;
        repeat (2) @(posedge ACLK);
        #1 manualRsp = 1'b0;
        repeat (3) @(negedge ACLK);
        check("issue_rsp_same_cycle", hsCount, 5);
        check("limit_after_overlap", sXferValid, 0);
        check("limit_no_proto_err", errCount - e0, 0);
        do_reset(1'b0);
        autoRsp = 1'b1;

        // Back-pressure: request held stable, then stray response while idle.
        xferReady = 1'b0;
        d0 = doneCount;
        e0 = errCount;
        start_cmd(1'b0, 3'd1, 4'd1, 14);
        repeat (5) begin
            @(negedge ACLK);
            check("stall_stable", {sXferValid, sXferBytes, sXferFirst, sXferLast},
                  {1'b1, 3'd3, 1'b1, 1'b0});
        end
        @(posedge ACLK); #1 xferReady = 1'b1;
        finish_cmd(4, d0, e0);
        @(posedge ACLK); #1 manualRsp = 1'b1;
        @(posedge ACLK); #1 manualRsp = 1'b0;
        @(negedge ACLK);
        check("proto_err_pulse", {sProtoErr, sCmdReady, sBusy}, 3'b110);
        @(negedge ACLK);
        check("proto_err_clear", sProtoErr, 0);

        // Reset in the middle of issuing abandons the command.
        autoRsp = 1'b0;
        start_cmd(1'b0, 3'd0, 4'd3, 32);
        repeat (2) @(negedge ACLK);
        check("pre_reset_issued", hsCount, 2);
        d0 = doneCount;
        #2 ARESETN = 1'b0;
        #1;
        check("reset_async", {sCmdReady, sBusy, sXferValid, sDone, sProtoErr, sXferFirst, sXferLast},
              7'b1000000);
        check("reset_async_total", sTotalBytes, 0);
        check("reset_async_bytes", sXferBytes, 0);
        repeat (2) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        expQ.delete();
        repeat (4) @(negedge ACLK);
        check("no_done_after_reset", doneCount - d0, 0);
        autoRsp = 1'b1;
        run_row(tab[1]);

        for (int i = 5; i < 9; i++) run_row(tab[i]);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
